// File: rtl/fetch_unit.sv
// fetch_unit: RV32 instruction fetch with one outstanding icache read and a single-entry decode buffer.
// Optional macro FETCH_PREDECODE_EN adds a registered jump/branch predecode hint.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h80000000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        branch_request_i,
  input  logic [31:0] branch_pc_i,
  output logic        icache_rd_o,
  output logic [31:0] icache_pc_o,
  input  logic        icache_accept_i,
  input  logic        icache_valid_i,
  input  logic [31:0] icache_inst_i,
  input  logic        icache_error_i,
  output logic        fetch_valid_o,
  output logic [31:0] fetch_instr_o,
  output logic [31:0] fetch_pc_o,
  output logic        fetch_fault_o,
  input  logic        fetch_accept_i,
  output logic        fetch_instr_branch_o
);
  typedef enum logic [1:0] {REQ, WAIT, STALL} state_t;
  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, addr_q, instr_q, instr_d, bpc_q, bpc_d;
  logic squash_q, squash_d, hold_q, hold_d, valid_q, valid_d, fault_q, fault_d, load;
  // A response is kept only if it belongs to the current path and no redirect arrives with it
  assign load = state_q == WAIT && icache_valid_i && !squash_q && !branch_request_i;
  // State register
  always_ff @(posedge clk_i) state_q <= !rst_i ? REQ : state_d;
  // Next state: REQ until accepted, WAIT for the response, STALL until the buffer frees up
  always_comb begin
    state_d = state_q;
    case (state_q)
      REQ:     state_d = icache_accept_i ? WAIT : REQ;
      WAIT:    state_d = !icache_valid_i ? WAIT : (squash_q || branch_request_i) ? REQ : STALL;
      STALL:   state_d = (branch_request_i || !valid_q || fetch_accept_i) ? REQ : STALL;
      default: state_d = REQ;
    endcase
  end
  // Outputs: a request already presented keeps its address even if pc_q was redirected
  always_comb begin
    icache_rd_o = rst_i && state_q == REQ;
    icache_pc_o = !rst_i ? 32'd0 : hold_q ? addr_q : pc_q;
  end
  // Datapath next state: PC, squash tracking and the output buffer
  always_comb begin
    pc_d     = branch_request_i ? branch_pc_i & ~32'd3 : load ? pc_q + 32'd4 : pc_q;
    squash_d = state_q == WAIT ? !icache_valid_i && (squash_q || branch_request_i)
                               : (squash_q && !icache_valid_i) || (state_q == REQ && branch_request_i);
    hold_d   = icache_rd_o && !icache_accept_i;
    valid_d  = !branch_request_i && (load || (valid_q && !fetch_accept_i));
    instr_d  = load ? icache_inst_i : instr_q;
    bpc_d    = load ? pc_q : bpc_q;
    fault_d  = load ? icache_error_i : fault_q;
  end
  // Datapath registers; reset keeps squash armed while an accepted read is still in flight
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      pc_q     <= RESET_PC & ~32'd3;
      addr_q   <= 32'd0;
      hold_q   <= 1'b0;
      squash_q <= (state_q == WAIT || squash_q) && !icache_valid_i;
      valid_q  <= 1'b0;
      instr_q  <= 32'd0;
      bpc_q    <= 32'd0;
      fault_q  <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      addr_q   <= icache_pc_o;
      hold_q   <= hold_d;
      squash_q <= squash_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      bpc_q    <= bpc_d;
      fault_q  <= fault_d;
    end
  end
  assign fetch_valid_o = valid_q;
  assign fetch_instr_o = instr_q;
  assign fetch_pc_o    = bpc_q;
  assign fetch_fault_o = fault_q;
`ifdef FETCH_PREDECODE_EN
  logic br_q, br_d;
  // Predecode JAL/JALR/Bxx alongside the buffered word; faulted words never hint
  always_comb br_d = load ? !icache_error_i && icache_inst_i[6:0] inside {7'b1101111, 7'b1100111, 7'b1100011} : br_q;
  // Hint register
  always_ff @(posedge clk_i) br_q <= !rst_i ? 1'b0 : br_d;
  assign fetch_instr_branch_o = br_q;
`else
  assign fetch_instr_branch_o = 1'b0;
`endif
endmodule
